// File: rtl/mist_spi_pkg.sv
// Shared command codes and FSM state type for the guest-side SPI responder.
package mist_spi_pkg;

    localparam logic [7:0] CMD_BUT_SW = 8'h01;
    localparam logic [7:0] CMD_JOY0   = 8'h02;
    localparam logic [7:0] CMD_JOY1   = 8'h03;
    localparam logic [7:0] CMD_KBD    = 8'h05;
    localparam logic [7:0] CMD_STATUS = 8'h1E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } resp_state_t;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer bringing an SPI pin into the clk domain.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mist_spi_responder.sv
// Oversampling SPI mode-0 responder decoding user_io command frames into core controls.
//   state | meaning
//   IDLE  | deselected, SCK ignored
//   CMD   | shifting the command byte, MISO returns CORE_TYPE
//   DATA  | shifting data bytes, acting on cmd_q
module mist_spi_responder
    import mist_spi_pkg::*;
#(
    parameter logic [7:0] CORE_TYPE   = 8'hA4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_ss_n,
    input  logic        spi_di,
    output logic        spi_do,
    output logic        spi_do_oe,
    output logic [1:0]  buttons,
    output logic [1:0]  switches,
    output logic [7:0]  joystick_0,
    output logic [7:0]  joystick_1,
    output logic [31:0] status,
    output logic [7:0]  kbd_data,
    output logic        kbd_valid,
    output logic        frame_err
);

    logic sck_s, ss_s, di_s;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk(clk), .rst_n(reset_n), .d(spi_sck),  .q(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss  (.clk(clk), .rst_n(reset_n), .d(spi_ss_n), .q(ss_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_di  (.clk(clk), .rst_n(reset_n), .d(spi_di),   .q(di_s));

    resp_state_t state_q, state_d;
    logic        sck_prev_q, sck_prev_d, ss_prev_q, ss_prev_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d, byte_idx_q, byte_idx_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [6:0]  rx_q, rx_d, tx_q, tx_d;
    logic        do_q, do_d, oe_q, oe_d;
    logic [1:0]  buttons_q, buttons_d, switches_q, switches_d;
    logic [7:0]  joy0_q, joy0_d, joy1_q, joy1_d, kbd_data_q, kbd_data_d;
    logic [23:0] shadow_q, shadow_d;
    logic [31:0] status_q, status_d;
    logic        kbd_valid_q, kbd_valid_d, frame_err_q, frame_err_d;

    logic       sck_rise, sck_fall, ss_fall, ss_rise;
    logic [7:0] rx_byte;

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ss_fall  = ~ss_s & ss_prev_q;
    assign ss_rise  = ss_s & ~ss_prev_q;
    assign rx_byte  = {rx_q, di_s};

    always_comb begin
        state_d     = state_q;
        sck_prev_d  = sck_s;
        ss_prev_d   = ss_s;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        cmd_d       = cmd_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        do_d        = do_q;
        oe_d        = oe_q;
        buttons_d   = buttons_q;
        switches_d  = switches_q;
        joy0_d      = joy0_q;
        joy1_d      = joy1_q;
        kbd_data_d  = kbd_data_q;
        shadow_d    = shadow_q;
        status_d    = status_q;
        kbd_valid_d = 1'b0;
        frame_err_d = 1'b0;

        // Deselect outranks a coincident SCK rise so the final bit is dropped.
        if (ss_rise) begin
            state_d   = IDLE;
            oe_d      = 1'b0;
            do_d      = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q != IDLE && bit_cnt_q != 3'd0) begin
                frame_err_d = 1'b1;
            end
        end else if (ss_fall) begin
            state_d    = CMD;
            bit_cnt_d  = 3'd0;
            byte_idx_d = 3'd0;
            tx_d       = CORE_TYPE[6:0];
            do_d       = CORE_TYPE[7];
            oe_d       = 1'b1;
        end else if (state_q != IDLE) begin
            if (sck_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == CMD) begin
                        cmd_d   = rx_byte;
                        state_d = DATA;
                        tx_d    = 7'd0;
                    end else begin
                        case (cmd_q)
                            CMD_BUT_SW: if (byte_idx_q == 3'd0) begin
                                buttons_d  = rx_byte[1:0];
                                switches_d = rx_byte[3:2];
                            end
                            CMD_JOY0: if (byte_idx_q == 3'd0) joy0_d = rx_byte;
                            CMD_JOY1: if (byte_idx_q == 3'd0) joy1_d = rx_byte;
                            CMD_KBD: begin
                                kbd_data_d  = rx_byte;
                                kbd_valid_d = 1'b1;
                            end
                            CMD_STATUS: begin
                                case (byte_idx_q)
                                    3'd0:    shadow_d[7:0]   = rx_byte;
                                    3'd1:    shadow_d[15:8]  = rx_byte;
                                    3'd2:    shadow_d[23:16] = rx_byte;
                                    3'd3:    status_d        = {rx_byte, shadow_q};
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                        if (byte_idx_q != 3'd7) begin
                            byte_idx_d = byte_idx_q + 3'd1;
                        end
                    end
                end
            end else if (sck_fall) begin
                do_d = tx_q[6];
                tx_d = {tx_q[5:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b0;
            bit_cnt_q   <= 3'd0;
            byte_idx_q  <= 3'd0;
            cmd_q       <= 8'd0;
            rx_q        <= 7'd0;
            tx_q        <= 7'd0;
            do_q        <= 1'b0;
            oe_q        <= 1'b0;
            buttons_q   <= 2'd0;
            switches_q  <= 2'd0;
            joy0_q      <= 8'd0;
            joy1_q      <= 8'd0;
            kbd_data_q  <= 8'd0;
            shadow_q    <= 24'd0;
            status_q    <= 32'd0;
            kbd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_prev_q  <= sck_prev_d;
            ss_prev_q   <= ss_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            cmd_q       <= cmd_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            do_q        <= do_d;
            oe_q        <= oe_d;
            buttons_q   <= buttons_d;
            switches_q  <= switches_d;
            joy0_q      <= joy0_d;
            joy1_q      <= joy1_d;
            kbd_data_q  <= kbd_data_d;
            shadow_q    <= shadow_d;
            status_q    <= status_d;
            kbd_valid_q <= kbd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_do     = do_q;
    assign spi_do_oe  = oe_q;
    assign buttons    = buttons_q;
    assign switches   = switches_q;
    assign joystick_0 = joy0_q;
    assign joystick_1 = joy1_q;
    assign status     = status_q;
    assign kbd_data   = kbd_data_q;
    assign kbd_valid  = kbd_valid_q;
    assign frame_err  = frame_err_q;

endmodule
